vcve2_vrf_mem_arbiter: RTL and testbench

VCVE2_VRF_MEM_ARBITER -- requirements
Module: vcve2_vrf_mem_arbiter

---
 rtl/vcve2_pkg.sv | 19 +
 rtl/vcve2_arb_id_fifo.sv | 63 ++++++
 rtl/vcve2_vrf_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vcve2_vrf_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vcve2_pkg.sv
// Shared constants and types for the VRF memory arbiter: requester-ID width,
// parameter upper bounds, queue pointer/count widths and the lock-state enum.
package vcve2_pkg;

   localparam int MaxNumReq           = 4;
   localparam int MaxOutstandingLimit = 4;

   localparam int IdWidth  = $clog2(MaxNumReq);
   localparam int PtrWidth = $clog2(MaxOutstandingLimit);
   localparam int CntWidth = $clog2(MaxOutstandingLimit + 1);

   typedef logic [IdWidth-1:0] req_id_t;

   typedef enum logic {
      ArbIdle,
      ArbLocked
   } arb_state_e;

endpackage

// File: rtl/vcve2_arb_id_fifo.sv
// In-flight response-ID queue for the VRF memory arbiter. Holds the ID of every
// granted request until its response returns; pointers wrap modulo Depth.
// The caller never pushes when full and never pops when empty.
module vcve2_arb_id_fifo
   import vcve2_pkg::*;
#(
   parameter int Depth = 2
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push_i,
   input  req_id_t push_id_i,
   input  logic    pop_i,
   output req_id_t head_id_o,
   output logic    empty_o,
   output logic    full_o
);

   logic [PtrWidth-1:0] wr_ptr_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [CntWidth-1:0] count_q;
   req_id_t             mem_q [MaxOutstandingLimit];

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
      if (ptr == PtrWidth'(Depth - 1)) begin
         return '0;
      end
      return ptr + PtrWidth'(1);
   endfunction

   assign head_id_o = mem_q[rd_ptr_q];
   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CntWidth'(Depth));

   // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (push_i && !pop_i) begin
            count_q <= count_q + CntWidth'(1);
         end else if (pop_i && !push_i) begin
            count_q <= count_q - CntWidth'(1);
         end
      end
   end

   // Storage needs no reset: entries are only read once the count covers them.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_id_i;
      end
   end

endmodule

// File: rtl/vcve2_vrf_mem_arbiter.sv
// Arbitrates VRF interfaces and the scalar LSU onto one memory port.
// A request that is presented but not granted is locked until granted or
// withdrawn; response IDs are tracked in order by vcve2_arb_id_fifo.
// Define VCVE2_ARB_RR_EN for round-robin; otherwise fixed priority (index 0 first).
module vcve2_vrf_mem_arbiter
   import vcve2_pkg::*;
#(
   parameter int NumReq         = 2,
   parameter int MaxOutstanding = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NumReq-1:0]      req_i,
   input  logic [NumReq-1:0]      we_i,
   input  logic [4*NumReq-1:0]    be_i,
   input  logic [32*NumReq-1:0]   addr_i,
   input  logic [32*NumReq-1:0]   wdata_i,
   output logic [NumReq-1:0]      gnt_o,
   output logic [NumReq-1:0]      rvalid_o,
   output logic [NumReq-1:0]      err_o,
   output logic [31:0]            rdata_o,
   output logic                   data_req_o,
   output logic                   data_we_o,
   output logic [3:0]             data_be_o,
   output logic [31:0]            data_addr_o,
   output logic [31:0]            data_wdata_o,
   input  logic                   data_gnt_i,
   input  logic                   data_rvalid_i,
   input  logic                   data_err_i,
   input  logic [31:0]            data_rdata_i,
   output logic                   protocol_err_o
);

   arb_state_e state_q;
   arb_state_e state_d;
   req_id_t    lock_id_q;
   req_id_t    win_id;
   logic       win_valid;
   logic       push;
   logic       pop;
   logic       fifo_empty;
   logic       fifo_full;
   req_id_t    head_id;

`ifdef VCVE2_ARB_RR_EN
   req_id_t prio_q;

   // Rotate priority past the requester that was just granted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q <= '0;
      end else if (push) begin
         if (win_id == req_id_t'(NumReq - 1)) begin
            prio_q <= '0;
         end else begin
            prio_q <= win_id + req_id_t'(1);
         end
      end
   end
`endif

   // Pick the winner: the locked requester if any, else by priority.
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      if (state_q == ArbLocked) begin
         win_id = lock_id_q;
         for (int k = 0; k < NumReq; k++) begin
            if (lock_id_q == req_id_t'(k)) begin
               win_valid = req_i[k];
            end
         end
      end else begin
`ifdef VCVE2_ARB_RR_EN
         for (int k = 0; k < NumReq; k++) begin
            if (!win_valid && req_i[k] && (req_id_t'(k) >= prio_q)) begin
               win_valid = 1'b1;
               win_id    = req_id_t'(k);
            end
         end
`endif
         for (int k = 0; k < NumReq; k++) begin
            if (!win_valid && req_i[k]) begin
               win_valid = 1'b1;
               win_id    = req_id_t'(k);
            end
         end
      end
   end

   // Drive the memory request with the winner's fields; everything idles at zero.
   always_comb begin
      data_req_o   = rst_ni & win_valid & ~fifo_full;
      data_we_o    = 1'b0;
      data_be_o    = '0;
      data_addr_o  = '0;
      data_wdata_o = '0;
      gnt_o        = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (data_req_o && (win_id == req_id_t'(k))) begin
            data_we_o    = we_i[k];
            data_be_o    = be_i[4*k +: 4];
            data_addr_o  = addr_i[32*k +: 32];
            data_wdata_o = wdata_i[32*k +: 32];
            gnt_o[k]     = data_gnt_i;
         end
      end
   end

   // Route responses to the oldest outstanding requester; orphans are flagged.
   always_comb begin
      pop            = data_rvalid_i & ~fifo_empty;
      protocol_err_o = rst_ni & data_rvalid_i & fifo_empty;
      rdata_o        = rst_ni ? data_rdata_i : '0;
      rvalid_o       = '0;
      err_o          = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (pop && (head_id == req_id_t'(k))) begin
            rvalid_o[k] = 1'b1;
            err_o[k]    = data_err_i;
         end
      end
   end

   assign push = data_req_o & data_gnt_i;

   // Lock whenever a request is presented but not granted this cycle.
   always_comb begin
      state_d = ArbIdle;
      if (data_req_o && !data_gnt_i) begin
         state_d = ArbLocked;
      end
   end

   // Lock state and the identity of the locked requester.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ArbIdle;
         lock_id_q <= '0;
      end else begin
         state_q <= state_d;
         if (data_req_o && !data_gnt_i) begin
            lock_id_q <= win_id;
         end
      end
   end

   vcve2_arb_id_fifo #(
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (push),
      .push_id_i (win_id),
      .pop_i     (pop),
      .head_id_o (head_id),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

endmodule

// File: tb/tb_vcve2_vrf_mem_arbiter.sv
// Directed self-checking bench for vcve2_vrf_mem_arbiter (NumReq=2, MaxOutstanding=2).
// Expected grant order follows VCVE2_ARB_RR_EN when it is defined for the build.
module tb_vcve2_vrf_mem_arbiter;

   logic        clock;
   logic        rstN;
   logic [1:0]  reqI;
   logic [1:0]  weI;
   logic [7:0]  beI;
   logic [63:0] addrI;
   logic [63:0] wdataI;
   logic [1:0]  gntO;
   logic [1:0]  rvalidO;
   logic [1:0]  errO;
   logic [31:0] rdataO;
   logic        dataReqO;
   logic        dataWeO;
   logic [3:0]  dataBeO;
   logic [31:0] dataAddrO;
   logic [31:0] dataWdataO;
   logic        dataGntI;
   logic        dataRvalidI;
   logic        dataErrI;
   logic [31:0] dataRdataI;
   logic        protocolErrO;

   int compareCount;
   int mismatchCount;

   logic [1:0] expGnt [4];

   vcve2_vrf_mem_arbiter #(
      .NumReq         (2),
      .MaxOutstanding (2)
   ) dut (
      .clk_i          (clock),
      .rst_ni         (rstN),
      .req_i          (reqI),
      .we_i           (weI),
      .be_i           (beI),
      .addr_i         (addrI),
      .wdata_i        (wdataI),
      .gnt_o          (gntO),
      .rvalid_o       (rvalidO),
      .err_o          (errO),
      .rdata_o        (rdataO),
      .data_req_o     (dataReqO),
      .data_we_o      (dataWeO),
      .data_be_o      (dataBeO),
      .data_addr_o    (dataAddrO),
      .data_wdata_o   (dataWdataO),
      .data_gnt_i     (dataGntI),
      .data_rvalid_i  (dataRvalidI),
      .data_err_i     (dataErrI),
      .data_rdata_i   (dataRdataI),
      .protocol_err_o (protocolErrO)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge, then let the logic settle.
   task automatic applyStimulus(input logic rst, input logic [1:0] req, input logic gnt,
                                input logic rvalid, input logic err, input logic [31:0] rdata);
      @(posedge clock);
      #1;
      rstN        = rst;
      reqI        = req;
      dataGntI    = gnt;
      dataRvalidI = rvalid;
      dataErrI    = err;
      dataRdataI  = rdata;
      #3;
   endtask

   // Directed sequence.
   initial begin
      compareCount  = 0;
      mismatchCount = 0;
`ifdef VCVE2_ARB_RR_EN
      expGnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      expGnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      weI    = 2'b10;
      beI    = {4'hC, 4'h3};
      addrI  = {32'h0000_0200, 32'h0000_0100};
      wdataI = {32'h2222_2222, 32'h1111_1111};
      rstN        = 1'b0;
      reqI        = 2'b11;
      dataGntI    = 1'b1;
      dataRvalidI = 1'b1;
      dataErrI    = 1'b1;
      dataRdataI  = 32'hDEAD_BEEF;
      #3;
      checkOutput("rst_data_req", {31'd0, dataReqO}, 32'd0);
      checkOutput("rst_gnt", {30'd0, gntO}, 32'd0);
      checkOutput("rst_rvalid", {30'd0, rvalidO}, 32'd0);
      checkOutput("rst_proto_err", {31'd0, protocolErrO}, 32'd0);
      checkOutput("rst_rdata", rdataO, 32'd0);
      checkOutput("rst_addr", dataAddrO, 32'd0);

      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("idle_data_req", {31'd0, dataReqO}, 32'd0);

      // Both requesters, always granted; responses trail grants by one cycle.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'b11, 1'b1, (i > 0), 1'b0, 32'h0000_0000);
         checkOutput("arb_gnt", {30'd0, gntO}, {30'd0, expGnt[i]});
         checkOutput("arb_addr", dataAddrO, (expGnt[i] == 2'b10) ? 32'h0000_0200 : 32'h0000_0100);
         checkOutput("arb_wdata", dataWdataO, (expGnt[i] == 2'b10) ? 32'h2222_2222 : 32'h1111_1111);
         checkOutput("arb_we", {31'd0, dataWeO}, (expGnt[i] == 2'b10) ? 32'd1 : 32'd0);
         if (i > 0) begin
            checkOutput("arb_rvalid", {30'd0, rvalidO}, {30'd0, expGnt[i-1]});
         end
      end
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("arb_drain_rvalid", {30'd0, rvalidO}, {30'd0, expGnt[3]});

      // Lock: requester 1 waits three cycles, requester 0 arrives meanwhile.
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("lock_req", {31'd0, dataReqO}, 32'd1);
      checkOutput("lock_addr_c1", dataAddrO, 32'h0000_0200);
      checkOutput("lock_gnt_c1", {30'd0, gntO}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 32'd0);
         checkOutput("lock_addr_hold", dataAddrO, 32'h0000_0200);
         checkOutput("lock_be_hold", {28'd0, dataBeO}, 32'h0000_000C);
         checkOutput("lock_gnt_hold", {30'd0, gntO}, 32'd0);
      end
      applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("lock_gnt_final", {30'd0, gntO}, 32'h0000_0002);
      checkOutput("lock_addr_final", dataAddrO, 32'h0000_0200);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
      checkOutput("lock_rvalid", {30'd0, rvalidO}, 32'h0000_0002);
      checkOutput("lock_rdata", rdataO, 32'h1234_5678);

      // Locked requester withdraws: lock must clear so requester 0 can win.
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("drop_req_c1", {31'd0, dataReqO}, 32'd1);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("drop_req_c2", {31'd0, dataReqO}, 32'd0);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("drop_req_c3", {31'd0, dataReqO}, 32'd1);
      checkOutput("drop_addr_c3", dataAddrO, 32'h0000_0100);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("drop_gnt_c4", {30'd0, gntO}, 32'h0000_0001);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("drop_rvalid", {30'd0, rvalidO}, 32'h0000_0001);

      // Queue full: third request blocked, even while a response pops.
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("full_req_1", {31'd0, dataReqO}, 32'd1);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("full_req_2", {31'd0, dataReqO}, 32'd1);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("full_req_3", {31'd0, dataReqO}, 32'd0);
      checkOutput("full_gnt_3", {30'd0, gntO}, 32'd0);
      checkOutput("full_addr_3", dataAddrO, 32'd0);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("full_req_pop", {31'd0, dataReqO}, 32'd0);
      checkOutput("full_rvalid_pop", {30'd0, rvalidO}, 32'h0000_0001);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("full_req_after", {31'd0, dataReqO}, 32'd1);
      checkOutput("full_gnt_after", {30'd0, gntO}, 32'h0000_0001);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0);
         checkOutput("full_drain", {30'd0, rvalidO}, 32'h0000_0001);
         checkOutput("full_drain_perr", {31'd0, protocolErrO}, 32'd0);
      end

      // Orphan response on an empty queue.
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("orphan_rvalid", {30'd0, rvalidO}, 32'd0);
      checkOutput("orphan_perr", {31'd0, protocolErrO}, 32'd1);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("orphan_perr_clear", {31'd0, protocolErrO}, 32'd0);

      // Response routing in order, with error flag on the second.
      applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("order_gnt_1", {30'd0, gntO}, 32'h0000_0002);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("order_gnt_0", {30'd0, gntO}, 32'h0000_0001);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001);
      checkOutput("order_rvalid_a", {30'd0, rvalidO}, 32'h0000_0002);
      checkOutput("order_rdata_a", rdataO, 32'hA5A5_0001);
      checkOutput("order_err_a", {30'd0, errO}, 32'd0);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_BEEF);
      checkOutput("order_rvalid_b", {30'd0, rvalidO}, 32'h0000_0001);
      checkOutput("order_rdata_b", rdataO, 32'h0000_BEEF);
      checkOutput("order_err_b", {30'd0, errO}, 32'h0000_0001);

      // Reset with two outstanding IDs discards them.
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 32'h5555_AAAA);
      checkOutput("mid_rst_rvalid", {30'd0, rvalidO}, 32'd0);
      checkOutput("mid_rst_perr", {31'd0, protocolErrO}, 32'd0);
      checkOutput("mid_rst_req", {31'd0, dataReqO}, 32'd0);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("post_rst_rvalid", {30'd0, rvalidO}, 32'd0);
      checkOutput("post_rst_perr", {31'd0, protocolErrO}, 32'd1);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("post_rst_req_1", {31'd0, dataReqO}, 32'd1);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("post_rst_req_2", {31'd0, dataReqO}, 32'd1);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("post_rst_req_3", {31'd0, dataReqO}, 32'd0);

      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
